// File: rtl/result_announcer.sv
// result_announcer: closes the poll, snapshots both tallies, converts them to BCD and drives
// a 4-digit multiplexed 7-seg display. Define RESULT_AUDIT_EN to audit vote_done pulses.
module result_announcer #(
   parameter int SCAN_BITS     = 16,
   parameter int BLANK_LEADING = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] votes0,
   input  logic [7:0] votes1,
   input  logic       vote_done,
   input  logic       close_polls,
   input  logic       show_select,
   output logic       polls_open,
   output logic       busy,
   output logic       result_valid,
   output logic       winner,
   output logic       tie,
   output logic [8:0] total_votes,
   output logic       mismatch,
   output logic [6:0] seg,
   output logic [3:0] an
);
   localparam logic [1:0] ST_OPEN    = 2'd0;
   localparam logic [1:0] ST_LATCH   = 2'd1;
   localparam logic [1:0] ST_CONVERT = 2'd2;
   localparam logic [1:0] ST_DONE    = 2'd3;
   localparam logic [6:0] SEG_DASH   = 7'b1000000;
   localparam logic [6:0] SEG_BLANK  = 7'b0000000;
   localparam logic       BLANK_EN   = (BLANK_LEADING != 32'sd0);

   logic [1:0]           state_r, state_nx_s;
   logic [2:0]           shift_cnt_r;
   logic [19:0]          dd0_r, dd1_r, dd0_nx_s, dd1_nx_s;
   logic [SCAN_BITS+1:0] scan_cnt_r, scan_nx_s;
   logic [1:0]           digit_nx_s;
   logic                 sel_r, sel_nx_s;
   logic [11:0]          bcd_sel_s;
   logic                 hund_blank_s, tens_blank_s;
   logic [6:0]           seg_nx_s, seg_r;
   logic [3:0]           an_r;
   logic                 polls_open_r, busy_r, result_valid_r, winner_r, tie_r, mismatch_r;
   logic [8:0]           total_r;

   // One double-dabble step on {hundreds, tens, ones, binary}: adjust nibbles, then shift.
   function automatic logic [19:0] dd_step(input logic [19:0] x);
      logic [19:0] y;
      y = x;
      for (int i = 0; i < 3; i++) begin
         if (y[8+4*i +: 4] >= 4'd5) y[8+4*i +: 4] = y[8+4*i +: 4] + 4'd3;
         else                       y[8+4*i +: 4] = y[8+4*i +: 4];
      end
      return {y[18:0], 1'b0};
   endfunction

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0:    seg_of = 7'b0111111;
         4'd1:    seg_of = 7'b0000110;
         4'd2:    seg_of = 7'b1011011;
         4'd3:    seg_of = 7'b1001111;
         4'd4:    seg_of = 7'b1100110;
         4'd5:    seg_of = 7'b1101101;
         4'd6:    seg_of = 7'b1111101;
         4'd7:    seg_of = 7'b0000111;
         4'd8:    seg_of = 7'b1111111;
         4'd9:    seg_of = 7'b1101111;
         default: seg_of = SEG_BLANK;
      endcase
   endfunction

   // Poll lifecycle; DONE is absorbing until reset.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_OPEN:    if (close_polls) state_nx_s = ST_LATCH; else state_nx_s = ST_OPEN;
         ST_LATCH:   state_nx_s = ST_CONVERT;
         ST_CONVERT: if (shift_cnt_r == 3'd7) state_nx_s = ST_DONE; else state_nx_s = ST_CONVERT;
         ST_DONE:    state_nx_s = ST_DONE;
         default:    state_nx_s = ST_OPEN;
      endcase
   end

   // Snapshot load and per-cycle conversion of both tallies.
   always_comb begin
      dd0_nx_s = dd0_r;
      dd1_nx_s = dd1_r;
      case (state_r)
         ST_LATCH: begin
            dd0_nx_s = {12'd0, votes0};
            dd1_nx_s = {12'd0, votes1};
         end
         ST_CONVERT: begin
            dd0_nx_s = dd_step(dd0_r);
            dd1_nx_s = dd_step(dd1_r);
         end
         default: begin
            dd0_nx_s = dd0_r;
            dd1_nx_s = dd1_r;
         end
      endcase
   end

   // Display content is computed from next-cycle values so seg and an stay aligned.
   always_comb begin
      scan_nx_s  = scan_cnt_r + {{(SCAN_BITS+1){1'b0}}, 1'b1};
      digit_nx_s = scan_nx_s[SCAN_BITS+1:SCAN_BITS];
      if (scan_nx_s[SCAN_BITS-1:0] == '0) sel_nx_s = show_select;
      else                                sel_nx_s = sel_r;
      if (sel_nx_s) bcd_sel_s = dd1_nx_s[19:8];
      else          bcd_sel_s = dd0_nx_s[19:8];
      hund_blank_s = BLANK_EN && (bcd_sel_s[11:8] == 4'd0);
      tens_blank_s = hund_blank_s && (bcd_sel_s[7:4] == 4'd0);
      seg_nx_s     = SEG_DASH;
      if (state_nx_s != ST_DONE) begin
         seg_nx_s = SEG_DASH;
      end else begin
         case (digit_nx_s)
            2'd3:    seg_nx_s = seg_of({3'd0, sel_nx_s});
            2'd2:    seg_nx_s = hund_blank_s ? SEG_BLANK : seg_of(bcd_sel_s[11:8]);
            2'd1:    seg_nx_s = tens_blank_s ? SEG_BLANK : seg_of(bcd_sel_s[7:4]);
            2'd0:    seg_nx_s = seg_of(bcd_sel_s[3:0]);
            default: seg_nx_s = SEG_DASH;
         endcase
      end
   end

   // Main state, conversion, result and display registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r        <= ST_OPEN;
         shift_cnt_r    <= 3'd0;
         dd0_r          <= 20'd0;
         dd1_r          <= 20'd0;
         winner_r       <= 1'b0;
         tie_r          <= 1'b0;
         total_r        <= 9'd0;
         polls_open_r   <= 1'b1;
         busy_r         <= 1'b0;
         result_valid_r <= 1'b0;
         scan_cnt_r     <= '0;
         sel_r          <= 1'b0;
         seg_r          <= SEG_DASH;
         an_r           <= 4'b0001;
      end else begin
         state_r     <= state_nx_s;
         shift_cnt_r <= (state_r == ST_CONVERT) ? shift_cnt_r + 3'd1 : 3'd0;
         dd0_r       <= dd0_nx_s;
         dd1_r       <= dd1_nx_s;
         if (state_r == ST_LATCH) begin
            winner_r <= (votes1 > votes0);
            tie_r    <= (votes0 == votes1);
            total_r  <= {1'b0, votes0} + {1'b0, votes1};
         end
         polls_open_r   <= (state_nx_s == ST_OPEN);
         busy_r         <= (state_nx_s == ST_LATCH) || (state_nx_s == ST_CONVERT);
         result_valid_r <= (state_nx_s == ST_DONE);
         scan_cnt_r     <= scan_nx_s;
         sel_r          <= sel_nx_s;
         seg_r          <= seg_nx_s;
         an_r           <= 4'b0001 << digit_nx_s;
      end
   end

`ifdef RESULT_AUDIT_EN
   logic [8:0] audit_cnt_r;

   // Independent count of accepted votes, compared against the snapshot sum.
   always_ff @(posedge clk) begin
      if (reset) begin
         audit_cnt_r <= 9'd0;
         mismatch_r  <= 1'b0;
      end else begin
         if ((state_r == ST_OPEN) && vote_done && (audit_cnt_r != 9'h1FF))
            audit_cnt_r <= audit_cnt_r + 9'd1;
         if (state_r == ST_LATCH)
            mismatch_r <= (audit_cnt_r != ({1'b0, votes0} + {1'b0, votes1}));
      end
   end
`else
   logic unused_vote_done_s;
   assign unused_vote_done_s = vote_done;
   assign mismatch_r         = 1'b0;
`endif

   assign polls_open   = polls_open_r;
   assign busy         = busy_r;
   assign result_valid = result_valid_r;
   assign winner       = winner_r;
   assign tie          = tie_r;
   assign total_votes  = total_r;
   assign mismatch     = mismatch_r;
   assign seg          = seg_r;
   assign an           = an_r;
endmodule
